sar_search: RTL



---
 rtl/sar_search.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sar_search.sv
// sar_search: successive-approximation controller for an external magnitude
// comparator. It drives the trial (y) operand and walks one bit per accepted
// comparison from the MSB down, then verifies the final candidate.
//
// Optional build macro: SAR_ONEHOT_CHK_EN
//   When defined, any accepted comparison whose flags are not exactly one-hot
//   ends the search with found=0, and the extra output err is raised.
//
// state  | meaning
// IDLE   | waiting for start; result/found held from the last search
// EVAL   | walking bit pointer k from WIDTH-1 down to 0
// VERIFY | all bits resolved; confirm final candidate with one more compare
// DONE   | one-cycle completion pulse, then back to IDLE
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    output logic             trial_valid,
    input  logic             cmp_valid,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic             found,
`ifdef SAR_ONEHOT_CHK_EN
    output logic             err,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_MSB = KW'(WIDTH - 1);
    localparam logic [KW-1:0] K_ONE = KW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic             flags_onehot;

    assign flags_onehot = (cmp_eq ^ cmp_gt ^ cmp_lt) & ~(cmp_eq & cmp_gt & cmp_lt);

    // State and datapath registers; reset aborts any search in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            k_q      <= K_MSB;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            k_q      <= k_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    // Next-state and bit-walk logic; trial only moves on accepted compares.
    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        k_d      = k_q;
        found_d  = found_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = EVAL;
                    trial_d        = '0;
                    trial_d[WIDTH-1] = 1'b1;
                    k_d            = K_MSB;
                    found_d        = 1'b0;
                    err_d          = 1'b0;
                end
            end
            EVAL: begin
                if (cmp_valid) begin
`ifdef SAR_ONEHOT_CHK_EN
                    if (!flags_onehot) begin
                        result_d = trial_q;
                        found_d  = 1'b0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else
`endif
                    if (cmp_eq) begin
                        result_d = trial_q;
                        found_d  = 1'b1;
                        state_d  = DONE;
                    end else if (cmp_gt) begin
                        if (k_q != '0) begin
                            trial_d[k_q - K_ONE] = 1'b1;
                            k_d                  = k_q - K_ONE;
                        end else begin
                            // Target above every candidate: comparator is inconsistent.
                            result_d = trial_q;
                            found_d  = 1'b0;
                            state_d  = DONE;
                        end
                    end else begin
                        // lt, or no flag at all, clears the bit under test.
                        trial_d[k_q] = 1'b0;
                        if (k_q != '0) begin
                            trial_d[k_q - K_ONE] = 1'b1;
                            k_d                  = k_q - K_ONE;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
            end
            VERIFY: begin
                if (cmp_valid) begin
                    result_d = trial_q;
                    found_d  = cmp_eq;
                    state_d  = DONE;
`ifdef SAR_ONEHOT_CHK_EN
                    if (!flags_onehot) begin
                        found_d = 1'b0;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign trial       = trial_q;
    assign trial_valid = (state_q == EVAL) || (state_q == VERIFY);
    assign busy        = (state_q == EVAL) || (state_q == VERIFY);
    assign done        = (state_q == DONE);
    assign found       = found_q;
    assign result      = result_q;
`ifdef SAR_ONEHOT_CHK_EN
    assign err         = err_q;
`else
    logic unused_chk;
    assign unused_chk  = flags_onehot ^ err_q ^ err_d;
`endif

endmodule
